// File: rtl/xor_checksum_acc.sv
// Streaming XOR checksum/parity accumulator. Folds each frame of WIDTH-bit words
// into a running XOR and holds the result (sum, parity, length, overflow) until taken.
module xor_checksum_acc #(
  parameter int WIDTH      = 8,
  parameter int MAX_LEN    = 16,
  parameter bit PARITY_ODD = 1'b0,
  parameter int LENW       = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [LENW-1:0]  out_len,
  output logic             out_err
);

  localparam logic [0:0]      ST_ACC  = 1'b0;
  localparam logic [0:0]      ST_HOLD = 1'b1;
  localparam logic [LENW-1:0] LEN_MAX = LENW'(MAX_LEN);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [LENW-1:0]  r_cnt;
  logic             r_ovf;
  logic [WIDTH-1:0] r_sum;
  logic             r_parity;
  logic [LENW-1:0]  r_len;
  logic             r_err;

  logic             w_accept;
  logic             w_at_max;
  logic [LENW-1:0]  w_cnt_inc;
  logic [WIDTH-1:0] w_sum_next;

  assign in_ready   = rst_n && (r_state == ST_ACC);
  assign out_valid  = (r_state == ST_HOLD);
  assign out_sum    = r_sum;
  assign out_parity = r_parity;
  assign out_len    = r_len;
  assign out_err    = r_err;

  assign w_accept   = in_valid && in_ready;
  assign w_at_max   = (r_cnt == LEN_MAX);
  // Count saturates; the XOR keeps folding past MAX_LEN so the sum stays exact.
  assign w_cnt_inc  = w_at_max ? r_cnt : r_cnt + LENW'(1);
  assign w_sum_next = r_acc ^ in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_ACC;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_sum    <= '0;
      r_parity <= 1'b0;
      r_len    <= '0;
      r_err    <= 1'b0;
    end else if (r_state == ST_ACC) begin
      if (w_accept) begin
        if (in_last) begin
          r_sum    <= w_sum_next;
          r_parity <= (^w_sum_next) ^ PARITY_ODD;
          r_len    <= w_cnt_inc;
          r_err    <= r_ovf || w_at_max;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_ovf    <= 1'b0;
          r_state  <= ST_HOLD;
        end else begin
          r_acc <= w_sum_next;
          r_cnt <= w_cnt_inc;
          if (w_at_max) begin
            r_ovf <= 1'b1;
          end
        end
      end
    end else begin
      if (out_ready) begin
        r_state <= ST_ACC;
      end
    end
  end

endmodule

// File: tb/tb_xor_checksum_acc.sv
// Scoreboard bench for xor_checksum_acc: directed frames from the test plan followed
// by randomized frames, gaps, back-pressure and mid-frame resets.
module tb_xor_checksum_acc;

  localparam int W  = 8;
  localparam int ML = 4;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;

  logic          in_ready, out_valid, out_parity, out_err;
  logic [W-1:0]  out_sum;
  logic [LW-1:0] out_len;
  logic          b_in_ready, b_out_valid, b_out_parity, b_out_err;
  logic [W-1:0]  b_out_sum;
  logic [LW-1:0] b_out_len;

  xor_checksum_acc #(.WIDTH(W), .MAX_LEN(ML), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_parity(out_parity),
    .out_len(out_len), .out_err(out_err)
  );

  xor_checksum_acc #(.WIDTH(W), .MAX_LEN(ML), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_parity(b_out_parity),
    .out_len(b_out_len), .out_err(b_out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  sum;
    logic [LW-1:0] len;
    logic          err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] frame_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int           n_frames = 0;
  exp_t         mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: checksum is the XOR of every word, length clips at ML, error when longer.
  function automatic exp_t model_frame(input logic [W-1:0] words[$]);
    exp_t e;
    int   n;
    e.sum = '0;
    foreach (words[k]) e.sum = e.sum ^ words[k];
    n     = words.size();
    e.len = LW'((n > ML) ? ML : n);
    e.err = (n > ML);
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compares the held result against the scoreboard head every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_during_reset", 32'(in_ready), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("odd_out_valid", 32'(b_out_valid), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        mon_e = exp_q[0];
        chk("out_sum", 32'(out_sum), 32'(mon_e.sum));
        chk("out_len", 32'(out_len), 32'(mon_e.len));
        chk("out_err", 32'(out_err), 32'(mon_e.err));
        chk("out_parity_even", 32'(out_parity), 32'(^mon_e.sum));
        chk("out_parity_odd", 32'(b_out_parity), 32'(~^mon_e.sum));
        if (out_ready) begin
          $display("frame %0d: sum=0x%02h parity=%0d len=%0d err=%0d",
                   n_frames, out_sum, out_parity, out_len, out_err);
          n_frames++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    logic rdy;
    int   waited;
    rdy    = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      waited++;
      if (waited > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_accept_timeout: got no in_ready, expected acceptance of 0x%02h", d);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_last  = 1'($urandom);
    if (rdy) begin
      frame_q.push_back(d);
      if (l) begin
        exp_q.push_back(model_frame(frame_q));
        frame_q.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = W'($urandom);
      in_last = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_parity", 32'(out_parity), 32'd0);
    chk("rst_out_len", 32'(out_len), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_odd_out_parity", 32'(b_out_parity), 32'd0);
    frame_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int waited;
    in_data = W'($urandom);
    do_reset(3);

    send_beat(8'hA5, 1'b1);
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    send_beat(8'h3C, 1'b1);

    // Same frame again under a 5+ cycle stall while a beat is offered throughout.
    ready_mode = 2;
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    send_beat(8'h3C, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    ready_mode = 0;
    send_beat(8'h77, 1'b1);

    repeat (6) send_beat(8'h01, 1'b0);
    frame_q.delete();
    idle(4);
    // The six-beat frame above has no last yet; restart it cleanly with a last on beat 6.
    do_reset(1);
    for (int k = 0; k < 6; k++) send_beat(8'h01, 1'(k == 5));
    send_beat(8'h80, 1'b1);

    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    do_reset(1);
    send_beat(8'h55, 1'b1);

    ready_mode = 1;
    for (int k = 0; k < 4; k++) begin
      idle($urandom_range(0, 3));
      send_beat(W'(1 << k), 1'(k == 3));
    end

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        idle($urandom_range(0, 2));
        if (k == len - 1 || $urandom_range(0, 29) != 0) begin
          send_beat(W'($urandom), 1'(k == len - 1));
        end else begin
          do_reset(1);
        end
      end
    end

    ready_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_checksum_acc.md
# xor_checksum_acc

Streaming XOR checksum and parity accumulator. It folds a frame of WIDTH-bit words, one word per accepted beat, into a running bitwise XOR. At the end of each frame it presents the checksum, a parity bit, the beat count and an overflow flag on a held output handshake. It sits after any word-stream source that needs a lightweight integrity check, and generalises the two-input xor gate to N bits × M beats with framing and flow control.

## Interface
Parameters:
- WIDTH, 8 — data word width in bits (≥1).
- MAX_LEN, 16 — maximum legal beats per frame (≥1); LENW = $clog2(MAX_LEN+1).
- PARITY_ODD, 0 — parity sense: 0 gives even parity (out_parity = ^out_sum); 1 gives odd parity (out_parity = ~^out_sum).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input word present.
- in_data  in  WIDTH  input word.
- in_last  in  1  marks the final beat of a frame; qualified by in_valid.
- in_ready  out  1  block can accept a beat.
- out_valid  out  1  frame result held.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  XOR of all accepted words in the frame.
- out_parity  out  1  parity of out_sum per PARITY_ODD.
- out_len  out  LENW  beats accepted, saturating at MAX_LEN.
- out_err  out  1  frame exceeded MAX_LEN beats.

## Operation
- Two states: ACC (accepting words) and HOLD (result presented).
- in_ready = rst_n && (state == ACC). out_valid = (state == HOLD).
- Beat accepted when in_valid && in_ready:
  - acc <= acc ^ in_data.
  - cnt <= cnt+1, saturating at MAX_LEN.
  - If cnt == MAX_LEN when the beat is accepted, set ovf (sticky).
  - XOR accumulation continues regardless of saturation.
- Last beat accepted (in_last=1):
  - out_sum <= acc ^ in_data.
  - out_len <= min(cnt+1, MAX_LEN).
  - out_err <= ovf || (cnt == MAX_LEN).
  - out_parity is computed from the new sum.
  - acc, cnt and ovf clear; state moves to HOLD.
- in_last sampled without in_valid is ignored. in_data is don't-care when in_valid=0.
- In HOLD:
  - out_* are registered and stable.
  - in_valid is ignored; nothing is accepted.
  - out_valid && out_ready moves the state to ACC on that edge.
- Reset (rst_n sampled low), at any point mid-frame or in HOLD:
  - State goes to ACC; acc, cnt and ovf clear.
  - out_valid, out_sum, out_parity, out_len and out_err all go to 0.
  - The partial frame is discarded with no output.

## Timing
- Reset values: out_valid=0, out_sum=0, out_parity=0, out_len=0, out_err=0. in_ready=0 while rst_n is low and 1 on the first cycle after release.
- Latency: out_valid rises on the edge that accepts the last beat, so it is visible 1 cycle after that beat.
- Throughput: 1 beat/cycle within a frame.
  - in_ready drops for the duration of HOLD: at minimum 1 cycle when out_ready is held high.
  - in_ready returns 1 the cycle after the result is taken.
- Outputs hold until accepted; out_valid does not drop without out_ready.
- Single-beat frames are legal: the result is valid the next cycle with out_len=1.
- No combinational path from in_* to out_*. in_ready depends only on state and rst_n, not on out_ready.

## Test plan
WIDTH=8, MAX_LEN=4, PARITY_ODD=0 unless noted.
- Single beat 0xA5 with last → next cycle out_valid=1, out_sum=0xA5, out_parity=0, out_len=1, out_err=0.
- Beats 0x0F, 0xF0, 0x3C (last on 0x3C), back-to-back → out_sum=0xC3, out_parity=0, out_len=3, out_err=0. Repeat with PARITY_ODD=1 → out_parity=1.
- Hold out_ready=0 for 5 cycles after the 0xC3 result while driving in_valid=1 → out_* stable, in_ready=0, no beats absorbed. Raise out_ready → next cycle out_valid=0, in_ready=1.
- Six beats of 0x01, last on the 6th → out_sum=0x00, out_len=4, out_err=1. Follow with a clean frame 0x80 → out_err=0, out_len=1.
- Two beats (0x11, 0x22), then rst_n=0 for 1 cycle, then single beat 0x55 last → out_sum=0x55, out_len=1. No output appears for the aborted frame.
- Frame 0x01, 0x02, 0x04, 0x08 with in_valid idle gaps of 0–3 cycles → out_sum=0x0F, out_len=4, out_err=0, identical to the gap-free run.
